// File: rtl/uart_cmd_transmitter.sv
// Turns rising edges on five command inputs into single-byte 8N1 UART frames.
// Requests queue in a one-bit-per-command pending set and drain in fixed priority.
module uart_cmd_transmitter #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_right,
  input  logic       i_left,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_trigger,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done,
  output logic [1:0] o_state
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [4:0]    pend_q, pend_d;
  logic [4:0]    prev_q;
  logic [4:0]    cmd, rise, grant;
  logic [7:0]    byte_sel;
  logic          take, bit_end;
  logic          tx_d, busy_d, done_d;

  // Bit order of the command vector doubles as priority: bit 0 wins.
  assign cmd     = {i_trigger, i_down, i_up, i_left, i_right};
  assign rise    = cmd & ~prev_q;
  assign bit_end = (cnt_q == CNT_LAST);
  assign o_state = state_q;

  always_comb begin
    grant    = 5'b00000;
    byte_sel = 8'h00;
    if (pend_q[0]) begin
      grant = 5'b00001; byte_sel = 8'h52;
    end else if (pend_q[1]) begin
      grant = 5'b00010; byte_sel = 8'h4C;
    end else if (pend_q[2]) begin
      grant = 5'b00100; byte_sel = 8'h55;
    end else if (pend_q[3]) begin
      grant = 5'b01000; byte_sel = 8'h44;
    end else if (pend_q[4]) begin
      grant = 5'b10000; byte_sel = 8'h54;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    take    = 1'b0;
    tx_d    = 1'b1;
    busy_d  = (state_q != IDLE);
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = 3'd0;
        if (pend_q != 5'b00000) begin
          shift_d = byte_sel;
          take    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new edge on a command that is still pending is dropped, never counted.
    pend_d = (pend_q & ~(take ? grant : 5'b00000)) | (rise & ~pend_q);
  end

  // Outputs are registered from the current state, so the line lags the FSM by one clock.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      pend_q  <= 5'b00000;
      prev_q  <= 5'b00000;
      o_tx    <= 1'b1;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      pend_q  <= pend_d;
      prev_q  <= cmd;
      o_tx    <= tx_d;
      o_busy  <= busy_d;
      o_done  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_transmitter.sv
// Bench for uart_cmd_transmitter at 4 clocks per bit: directed vector table,
// hand-written multi-cycle sequences, and a reference receiver with a queue model.
module tb_uart_cmd_transmitter;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] cmd_in = 5'b00000;
  logic       o_tx, o_busy, o_done;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  uart_cmd_transmitter #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_right  (cmd_in[0]),
    .i_left   (cmd_in[1]),
    .i_up     (cmd_in[2]),
    .i_down   (cmd_in[3]),
    .i_trigger(cmd_in[4]),
    .o_tx     (o_tx),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_state  (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model of the request queue, stepped at every clock edge
  logic [7:0] exp_q[$];
  logic [4:0] m_prev = 5'b00000;
  logic [4:0] m_pend = 5'b00000;
  int         m_timer = 0;

  function automatic logic [7:0] cmd_byte(input int i);
    case (i)
      0:       return 8'h52;
      1:       return 8'h4C;
      2:       return 8'h55;
      3:       return 8'h44;
      default: return 8'h54;
    endcase
  endfunction

  task model_step();
    logic [4:0] g;
    logic [4:0] r;
    if (!rst_n) begin
      if (m_timer > 0 && exp_q.size() > 0) void'(exp_q.pop_back());
      m_prev  = 5'b00000;
      m_pend  = 5'b00000;
      m_timer = 0;
    end else begin
      g = 5'b00000;
      if (m_timer > 0) begin
        m_timer--;
      end else if (m_pend != 5'b00000) begin
        for (int i = 0; i < 5; i++) begin
          if (g == 5'b00000 && m_pend[i]) begin
            g[i] = 1'b1;
            exp_q.push_back(cmd_byte(i));
          end
        end
        m_timer = 40;
      end
      r      = cmd_in & ~m_prev;
      m_pend = (m_pend & ~g) | (r & ~m_pend);
      m_prev = cmd_in;
    end
  endtask

  // driver tasks
  task tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
  endtask

  task ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0 && m_pend == 5'b00000 && m_timer == 0 && !rx_active) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    ticks(3);
    check("drain_idle", {31'd0, ok}, 32'd1);
  endtask

  // reference receiver and scoreboard, sampling on the falling edge
  bit         mon_en = 1'b0;
  bit         rx_active = 1'b0;
  int         rx_pos = 0;
  logic [39:0] rx_s;
  logic [7:0] last_rx = 8'h00;
  int         rx_frames = 0;
  int         done_count = 0;

  task finish_frame();
    logic [7:0] b;
    bit stable;
    stable = 1'b1;
    for (int k = 0; k < 10; k++)
      for (int j = 1; j < CPB; j++)
        if (rx_s[k*CPB+j] !== rx_s[k*CPB]) stable = 1'b0;
    check("bit_stable", {31'd0, stable}, 32'd1);
    check("start_bit", {31'd0, rx_s[0]}, 32'd0);
    check("stop_bit", {31'd0, rx_s[9*CPB]}, 32'd1);
    for (int k = 0; k < 8; k++) b[k] = rx_s[(k+1)*CPB];
    last_rx = b;
    rx_frames++;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame: got %0h expected no frame (cycle %0d)", b, cyc);
    end else begin
      check("frame_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) begin
        rx_active = 1'b0;
      end else begin
        if (!rx_active && o_tx === 1'b0) begin
          rx_active = 1'b1;
          rx_pos    = 0;
        end else if (rx_active) begin
          rx_pos++;
        end
        if (rx_active) rx_s[rx_pos] = o_tx;
        if (o_done === 1'b1) done_count++;
        check("busy_shape", {31'd0, o_busy}, {31'd0, rx_active});
        check("done_shape", {31'd0, o_done}, {31'd0, (rx_active && rx_pos == 10*CPB-1)});
        if (rx_active && rx_pos == 10*CPB-1) begin
          finish_frame();
          rx_active = 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic [4:0] cmd;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int f0, d0;
    vecs[0] = '{cmd: 5'b00001, exp_byte: 8'h52};
    vecs[1] = '{cmd: 5'b00010, exp_byte: 8'h4C};
    vecs[2] = '{cmd: 5'b00100, exp_byte: 8'h55};
    vecs[3] = '{cmd: 5'b01000, exp_byte: 8'h44};
    vecs[4] = '{cmd: 5'b10000, exp_byte: 8'h54};

    // reset state
    rst_n = 1'b0;
    ticks(3);
    check("rst_tx", {31'd0, o_tx}, 32'd1);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    ticks(2);

    // single-command frames: latency, done timing, decoded byte
    for (int v = 0; v < 5; v++) begin
      f0 = rx_frames;
      cmd_in = vecs[v].cmd;
      tick();                                   // edge k
      cmd_in = 5'b00000;
      tick();                                   // k+1
      check("pre_start_tx", {31'd0, o_tx}, 32'd1);
      tick();                                   // k+2
      check("start_tx", {31'd0, o_tx}, 32'd0);
      check("start_busy", {31'd0, o_busy}, 32'd1);
      ticks(38);                                // k+40
      check("done_early", {31'd0, o_done}, 32'd0);
      tick();                                   // k+41
      check("done_k41", {31'd0, o_done}, 32'd1);
      check("stop_tx", {31'd0, o_tx}, 32'd1);
      tick();                                   // k+42
      check("busy_after", {31'd0, o_busy}, 32'd0);
      check("table_frames", rx_frames, f0 + 1);
      check("table_byte", {24'd0, last_rx}, {24'd0, vecs[v].exp_byte});
    end

    // right and trigger on the same edge: two frames, one idle clock between
    f0 = rx_frames; d0 = done_count;
    cmd_in = 5'b10001;
    tick();                                     // k
    cmd_in = 5'b00000;
    ticks(41);                                  // k+41
    check("pair_done1", {31'd0, o_done}, 32'd1);
    tick();                                     // k+42
    check("pair_gap_tx", {31'd0, o_tx}, 32'd1);
    check("pair_gap_busy", {31'd0, o_busy}, 32'd0);
    tick();                                     // k+43
    check("pair_start2", {31'd0, o_tx}, 32'd0);
    ticks(39);                                  // k+82
    check("pair_done2", {31'd0, o_done}, 32'd1);
    drain();
    check("pair_frames", rx_frames, f0 + 2);
    check("pair_dones", done_count, d0 + 2);

    // left held high with three re-edges during its frame
    f0 = rx_frames; d0 = done_count;
    cmd_in = 5'b00010;
    ticks(10);
    for (int t = 0; t < 3; t++) begin
      cmd_in = 5'b00000; tick();
      cmd_in = 5'b00010; tick();
    end
    ticks(184);
    cmd_in = 5'b00000;
    drain();
    check("hold_frames", rx_frames, f0 + 2);
    check("hold_dones", done_count, d0 + 2);
    check("hold_byte", {24'd0, last_rx}, 32'h4C);

    // reset during data bit 3 with a second request queued
    f0 = rx_frames; d0 = done_count;
    cmd_in = 5'b00100;
    tick();                                     // k
    cmd_in = 5'b00000;
    ticks(4);
    cmd_in = 5'b00001;
    tick();                                     // k+5
    cmd_in = 5'b00000;
    ticks(13);                                  // k+18
    check("abort_bit3_tx", {31'd0, o_tx}, 32'd0);
    rst_n = 1'b0;
    tick();                                     // k+19
    check("abort_tx", {31'd0, o_tx}, 32'd1);
    check("abort_busy", {31'd0, o_busy}, 32'd0);
    check("abort_done", {31'd0, o_done}, 32'd0);
    check("abort_state", {30'd0, dbg_state}, 32'd0);
    ticks(2);
    rst_n = 1'b1;
    ticks(60);
    check("abort_frames", rx_frames, f0);
    check("abort_dones", done_count, d0);
    check("abort_queue", exp_q.size(), 0);

    // down held high through reset release: exactly one frame
    f0 = rx_frames;
    rst_n  = 1'b0;
    cmd_in = 5'b01000;
    ticks(3);
    rst_n = 1'b1;
    tick();                                     // release edge r
    check("rel_r_tx", {31'd0, o_tx}, 32'd1);
    tick();                                     // r+1
    check("rel_r1_tx", {31'd0, o_tx}, 32'd1);
    tick();                                     // r+2
    check("rel_start_tx", {31'd0, o_tx}, 32'd0);
    ticks(100);
    cmd_in = 5'b00000;
    drain();
    check("rel_frames", rx_frames, f0 + 1);
    check("rel_byte", {24'd0, last_rx}, 32'h44);

    // random edges against the queue model
    f0 = rx_frames;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 39) == 0) cmd_in[b] = ~cmd_in[b];
      tick();
    end
    cmd_in = 5'b00000;
    drain();
    check("rand_some_frames", {31'd0, (rx_frames > f0)}, 32'd1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
